// File: rtl/csr_pkg.sv
// Shared trap/CSR definitions: FSM states, mstatus fields,
// interrupt codes and mtvec mode decoding.
package csr_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UPDATE   = 2'd1,
    REDIRECT = 2'd2
  } trap_state_e;

  localparam int MST_MIE    = 3;
  localparam int MST_MPIE   = 7;
  localparam int MST_MPP_LO = 11;
  localparam int MST_MPP_HI = 12;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  // Reserved modes (>=2) fall back to direct.
  function automatic logic mtvec_vectored(
    input logic [1:0] mode
  );
    return mode == MTVEC_VECTORED;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Redirect handshake between the trap sequencer and PC control.
// The sequencer is master; PC control is slave.
interface trap_ctrl_if #(
  parameter int xlen = 32
);
  logic            redirect_v;
  logic [xlen-1:0] redirect_pc;
  logic            redirect_ready;

  modport master (
    output redirect_v,
    output redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  redirect_v,
    input  redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/trap_irq_select.sv
// Priority encoder for machine interrupts:
// MEI > MSI > MTI, gated by commit boundary and MIE.
module trap_irq_select
  import csr_pkg::*;
#(
  parameter int xlen = 32
) (
  input  logic [xlen-1:0] i_mip,
  input  logic [xlen-1:0] i_mie,
  input  logic            i_gate,
  output logic            o_valid,
  output logic [3:0]      o_code
);

  logic [xlen-1:0] w_pend;

  assign w_pend  = i_mip & i_mie & {xlen{i_gate}};
  assign o_valid = |w_pend;

  always_comb begin
    o_code = 4'd0;
    priority case (1'b1)
      w_pend[IRQ_MEI]: o_code = IRQ_MEI;
      w_pend[IRQ_MSI]: o_code = IRQ_MSI;
      w_pend[IRQ_MTI]: o_code = IRQ_MTI;
      default:         o_code = 4'd0;
    endcase
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: latches exception/mret/interrupt entry state,
// writes trap CSRs, flushes, then hands a redirect to PC control.
module trap_ctrl
  import csr_pkg::*;
#(
  parameter int xlen = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exc_v,
  input  logic [3:0]      exc_cause,
  input  logic [xlen-1:0] exc_pc,
  input  logic [xlen-1:0] exc_tval,
  input  logic            mret_v,
  input  logic            commit_v,
  input  logic [xlen-1:0] commit_npc,
  input  logic            msip,
  input  logic            mtip,
  input  logic            meip,
  input  logic [xlen-1:0] mstatus_i,
  input  logic [xlen-1:0] mie_i,
  input  logic [xlen-1:0] mtvec_i,
  input  logic [xlen-1:0] mepc_i,
  output logic            csr_we,
  output logic [xlen-1:0] mepc_o,
  output logic [xlen-1:0] mcause_o,
  output logic [xlen-1:0] mtval_o,
  output logic [xlen-1:0] mstatus_o,
  output logic [xlen-1:0] mip_o,
  output logic            flush,
  output logic            busy,
  trap_ctrl_if.master     rdr
);

  trap_state_e r_state;
  trap_state_e w_state_d;

  logic [xlen-1:0] r_mepc;
  logic [xlen-1:0] r_mcause;
  logic [xlen-1:0] r_mtval;
  logic [xlen-1:0] r_mstatus;
  logic [xlen-1:0] r_tgt;

  logic            w_irq_v;
  logic [3:0]      w_irq_code;
  logic [xlen-1:0] w_base;
  logic [xlen-1:0] w_vec_off;
  logic [xlen-1:0] w_irq_tgt;
  logic [xlen-1:0] w_st_entry;
  logic [xlen-1:0] w_st_mret;

  logic            w_take;
  logic [xlen-1:0] w_mepc;
  logic [xlen-1:0] w_mcause;
  logic [xlen-1:0] w_mtval;
  logic [xlen-1:0] w_mstatus;
  logic [xlen-1:0] w_tgt;

  always_comb begin
    mip_o          = '0;
    mip_o[IRQ_MSI] = msip;
    mip_o[IRQ_MTI] = mtip;
    mip_o[IRQ_MEI] = meip;
  end

  trap_irq_select #(
    .xlen (xlen)
  ) u_irq (
    .i_mip   (mip_o),
    .i_mie   (mie_i),
    .i_gate  (commit_v & mstatus_i[MST_MIE]),
    .o_valid (w_irq_v),
    .o_code  (w_irq_code)
  );

  assign w_base    = {mtvec_i[xlen-1:2], 2'b00};
  assign w_vec_off = {{(xlen-6){1'b0}}, w_irq_code, 2'b00};
  assign w_irq_tgt = mtvec_vectored(mtvec_i[1:0])
                   ? w_base + w_vec_off
                   : w_base;

  always_comb begin
    w_st_entry = mstatus_i;
    w_st_entry[MST_MPIE] = mstatus_i[MST_MIE];
    w_st_entry[MST_MIE]  = 1'b0;
    w_st_entry[MST_MPP_HI:MST_MPP_LO] = 2'b11;
    w_st_mret = mstatus_i;
    w_st_mret[MST_MIE]  = mstatus_i[MST_MPIE];
    w_st_mret[MST_MPIE] = 1'b1;
    w_st_mret[MST_MPP_HI:MST_MPP_LO] = 2'b11;
  end

  // mret keeps mcause/mtval at their last written values.
  always_comb begin
    w_take    = 1'b0;
    w_mepc    = r_mepc;
    w_mcause  = r_mcause;
    w_mtval   = r_mtval;
    w_mstatus = r_mstatus;
    w_tgt     = r_tgt;
    priority case (1'b1)
      exc_v: begin
        w_take    = 1'b1;
        w_mepc    = exc_pc;
        w_mcause  = {{(xlen-4){1'b0}}, exc_cause};
        w_mtval   = exc_tval;
        w_mstatus = w_st_entry;
        w_tgt     = w_base;
      end
      mret_v: begin
        w_take    = 1'b1;
        w_mepc    = mepc_i;
        w_mstatus = w_st_mret;
        w_tgt     = {mepc_i[xlen-1:2], 2'b00};
      end
      w_irq_v: begin
        w_take    = 1'b1;
        w_mepc    = commit_npc;
        w_mcause  = {1'b1, {(xlen-5){1'b0}}, w_irq_code};
        w_mtval   = '0;
        w_mstatus = w_st_entry;
        w_tgt     = w_irq_tgt;
      end
      default: w_take = 1'b0;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:     if (w_take) w_state_d = UPDATE;
      UPDATE:   w_state_d = REDIRECT;
      REDIRECT: if (rdr.redirect_ready) w_state_d = IDLE;
      default:  w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mepc    <= '0;
      r_mcause  <= '0;
      r_mtval   <= '0;
      r_mstatus <= '0;
      r_tgt     <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == IDLE && w_take) begin
        r_mepc    <= w_mepc;
        r_mcause  <= w_mcause;
        r_mtval   <= w_mtval;
        r_mstatus <= w_mstatus;
        r_tgt     <= w_tgt;
      end
    end
  end

  assign csr_we    = (r_state == UPDATE);
  assign flush     = (r_state == UPDATE);
  assign busy      = (r_state != IDLE);
  assign mepc_o    = r_mepc;
  assign mcause_o  = r_mcause;
  assign mtval_o   = r_mtval;
  assign mstatus_o = r_mstatus;

  assign rdr.redirect_v  = (r_state == REDIRECT);
  assign rdr.redirect_pc = r_tgt;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: entry, mret, priority,
// backpressure, masking and reset-in-redirect.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_v;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval;
  logic        mret_v, commit_v;
  logic [31:0] commit_npc;
  logic        msip, mtip, meip;
  logic [31:0] mstatus_i, mie_i, mtvec_i, mepc_i;
  logic        csr_we, flush, busy;
  logic [31:0] mepc_o, mcause_o, mtval_o, mstatus_o, mip_o;

  int checks = 0;
  int errors = 0;

  trap_ctrl_if #(.xlen(32)) rif ();

  trap_ctrl #(.xlen(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .exc_v      (exc_v),
    .exc_cause  (exc_cause),
    .exc_pc     (exc_pc),
    .exc_tval   (exc_tval),
    .mret_v     (mret_v),
    .commit_v   (commit_v),
    .commit_npc (commit_npc),
    .msip       (msip),
    .mtip       (mtip),
    .meip       (meip),
    .mstatus_i  (mstatus_i),
    .mie_i      (mie_i),
    .mtvec_i    (mtvec_i),
    .mepc_i     (mepc_i),
    .csr_we     (csr_we),
    .mepc_o     (mepc_o),
    .mcause_o   (mcause_o),
    .mtval_o    (mtval_o),
    .mstatus_o  (mstatus_o),
    .mip_o      (mip_o),
    .flush      (flush),
    .busy       (busy),
    .rdr        (rif.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 0; exc_v = 0; exc_cause = 0; exc_pc = 0;
    exc_tval = 0; mret_v = 0; commit_v = 0; commit_npc = 0;
    msip = 0; mtip = 0; meip = 0;
    mstatus_i = 0; mie_i = 0; mtvec_i = 0; mepc_i = 0;
    rif.redirect_ready = 1'b1;
    tick(); tick();
    rst_n = 1;
    tick();
    chk("rst_csr_we", {31'd0, csr_we}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_rv", {31'd0, rif.redirect_v}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mepc", mepc_o, 32'd0);
    chk("rst_mstatus", mstatus_o, 32'd0);
    chk("rst_rpc", rif.redirect_pc, 32'd0);

    msip = 1; mtip = 1; #1;
    chk("mip_img", mip_o, 32'h88);
    msip = 0; mtip = 0; #1;

    // exception
    mtvec_i = 32'h8001; mstatus_i = 32'h8;
    exc_v = 1; exc_cause = 4'd2;
    exc_pc = 32'h100; exc_tval = 32'hDEAD;
    tick();
    exc_v = 0;
    chk("exc_we", {31'd0, csr_we}, 32'd1);
    chk("exc_flush", {31'd0, flush}, 32'd1);
    chk("exc_rv_upd", {31'd0, rif.redirect_v}, 32'd0);
    chk("exc_mepc", mepc_o, 32'h100);
    chk("exc_mcause", mcause_o, 32'h2);
    chk("exc_mtval", mtval_o, 32'hDEAD);
    chk("exc_mstatus", mstatus_o, 32'h1880);
    tick();
    chk("exc_rv", {31'd0, rif.redirect_v}, 32'd1);
    chk("exc_rpc", rif.redirect_pc, 32'h8000);
    chk("exc_flush_rd", {31'd0, flush}, 32'd0);
    tick();
    chk("exc_idle", {31'd0, busy}, 32'd0);

    // vectored interrupt
    mie_i = 32'h80; mtip = 1;
    commit_v = 1; commit_npc = 32'h204;
    tick();
    commit_v = 0;
    chk("irq_mcause", mcause_o, 32'h80000007);
    chk("irq_mepc", mepc_o, 32'h204);
    chk("irq_mtval", mtval_o, 32'h0);
    chk("irq_mstatus", mstatus_o, 32'h1880);
    tick();
    chk("irq_rpc", rif.redirect_pc, 32'h801C);
    tick();
    mtip = 0;

    // mret
    mstatus_i = 32'h1880; mepc_i = 32'h206; mret_v = 1;
    tick();
    mret_v = 0;
    chk("mret_mstatus", mstatus_o, 32'h1888);
    chk("mret_mepc", mepc_o, 32'h206);
    chk("mret_mcause", mcause_o, 32'h80000007);
    tick();
    chk("mret_rpc", rif.redirect_pc, 32'h204);
    tick();

    // exception beats mret
    mstatus_i = 32'h8;
    exc_v = 1; mret_v = 1; exc_cause = 4'd5;
    exc_pc = 32'h300; exc_tval = 32'h44;
    tick();
    exc_v = 0; mret_v = 0;
    chk("pri_mcause", mcause_o, 32'h5);
    chk("pri_mepc", mepc_o, 32'h300);
    chk("pri_mstatus", mstatus_o, 32'h1880);
    tick();
    chk("pri_rpc", rif.redirect_pc, 32'h8000);
    tick();
    chk("pri_idle", {31'd0, busy}, 32'd0);

    // all irqs pending, plus backpressure
    mie_i = 32'h888; msip = 1; mtip = 1; meip = 1;
    commit_v = 1; commit_npc = 32'h400;
    rif.redirect_ready = 0;
    tick();
    commit_v = 0;
    chk("irqp_mcause", mcause_o, 32'h8000000B);
    for (int i = 0; i < 5; i++) begin
      tick();
      exc_v = (i == 1);
      exc_cause = 4'd9;
      chk("bp_rv", {31'd0, rif.redirect_v}, 32'd1);
      chk("bp_rpc", rif.redirect_pc, 32'h802C);
    end
    exc_v = 0;
    chk("bp_mcause", mcause_o, 32'h8000000B);
    chk("bp_mepc", mepc_o, 32'h400);
    rif.redirect_ready = 1;
    tick();
    chk("bp_idle", {31'd0, busy}, 32'd0);

    // MIE clear masks interrupts
    mstatus_i = 32'h0; commit_v = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mask_busy", {31'd0, busy}, 32'd0);
    end
    commit_v = 0;
    msip = 0; meip = 0;

    // reserved mtvec mode acts as direct
    mtvec_i = 32'h8002; mstatus_i = 32'h8; mie_i = 32'h80;
    commit_v = 1; commit_npc = 32'h500;
    tick();
    commit_v = 0;
    tick();
    chk("mode2_rpc", rif.redirect_pc, 32'h8000);
    tick();
    mtip = 0;

    // reset while redirecting
    rif.redirect_ready = 0;
    exc_v = 1; exc_cause = 4'd1; exc_pc = 32'h700;
    tick();
    exc_v = 0;
    tick();
    chk("rr_rv", {31'd0, rif.redirect_v}, 32'd1);
    rst_n = 0;
    tick();
    rst_n = 1; rif.redirect_ready = 1;
    chk("rr_rv0", {31'd0, rif.redirect_v}, 32'd0);
    chk("rr_busy", {31'd0, busy}, 32'd0);
    chk("rr_mepc", mepc_o, 32'd0);
    chk("rr_mcause", mcause_o, 32'd0);
    chk("rr_mtval", mtval_o, 32'd0);
    chk("rr_mstatus", mstatus_o, 32'd0);
    chk("rr_rpc", rif.redirect_pc, 32'd0);
    exc_v = 1; exc_cause = 4'd4;
    exc_pc = 32'h600; exc_tval = 32'h12;
    tick();
    exc_v = 0;
    chk("post_we", {31'd0, csr_we}, 32'd1);
    chk("post_mcause", mcause_o, 32'h4);
    chk("post_mepc", mepc_o, 32'h600);
    tick();
    chk("post_rpc", rif.redirect_pc, 32'h8000);
    tick();
    chk("post_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
